// File: rtl/irq_pkg.sv
// Shared constants and helpers for the external-interrupt front end.
package irq_pkg;

    localparam int N_IRQ_DEF     = 3;
    localparam int DB_CYCLES_DEF = 16;
    localparam int MAX_IRQ       = 8;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } hsb_t;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    function automatic hsb_t highest_set(input logic [MAX_IRQ-1:0] v);
        hsb_t r;
        r = '0;
        for (int unsigned i = 0; i < MAX_IRQ; i++) begin
            if (v[i]) begin
                r.valid = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_debounce.sv
// One button line: two-flop synchroniser, disagreement counter and debounced state.
module irq_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int CW = $clog2(DB_CYCLES);

    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          expire;

    assign expire = (s2 != stable) && (cnt == CW'(DB_CYCLES - 1));
    // Combinational so the caller can latch the request on the same edge stable flips.
    assign rise   = expire & s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (expire) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt front end: per-line debounce, pending/in-service tracking and
// priority-nested request/ack/return handshake towards the CPU.
module irq_controller
    import irq_pkg::*;
#(
    parameter  int N_IRQ     = N_IRQ_DEF,
    parameter  int DB_CYCLES = DB_CYCLES_DEF,
    localparam int ID_W      = id_width(N_IRQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_raw,
    input  logic             ie,
    input  logic             int_ack,
    input  logic             int_eret,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id,
    output logic [N_IRQ-1:0] irw
);

    logic [N_IRQ-1:0] stable, rise;
    logic [N_IRQ-1:0] pending, in_service;
    logic [N_IRQ-1:0] pending_n, in_service_n;
    hsb_t             cand, cur;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_line
        irq_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk    (clk),
            .rst    (rst),
            .raw    (irq_raw[g]),
            .stable (stable[g]),
            .rise   (rise[g])
        );
    end

    assign cand    = highest_set(MAX_IRQ'(pending));
    assign cur     = highest_set(MAX_IRQ'(in_service));
    assign int_req = ie && cand.valid && (!cur.valid || (cand.idx > cur.idx));
    assign int_id  = int_req ? cand.idx[ID_W-1:0] : '0;
    assign irw     = pending | in_service;

    // Eret clears from pre-edge in_service before ack sets; a fresh rise beats the ack clear.
    always_comb begin
        pending_n    = pending;
        in_service_n = in_service;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (int_eret && cur.valid && (32'(cur.idx) == i))
                in_service_n[i] = 1'b0;
            if (int_ack && int_req && (32'(cand.idx) == i)) begin
                pending_n[i]    = 1'b0;
                in_service_n[i] = 1'b1;
            end
            if (rise[i])
                pending_n[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            in_service <= '0;
        end else begin
            pending    <= pending_n;
            in_service <= in_service_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert ((rise & stable) == '0);
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with N_IRQ=3, DB_CYCLES=4.
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] irq_raw;
    logic       ie, int_ack, int_eret;
    logic       int_req;
    logic [1:0] int_id;
    logic [2:0] irw;

    int n_checks = 0;
    int n_passed = 0;

    irq_controller #(.N_IRQ(3), .DB_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_raw  (irq_raw),
        .ie       (ie),
        .int_ack  (int_ack),
        .int_eret (int_eret),
        .int_req  (int_req),
        .int_id   (int_id),
        .irw      (irw)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_passed++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [2:0] m, input int n);
        irq_raw = irq_raw | m;
        tick(n);
        irq_raw = irq_raw & ~m;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
    endtask

    task automatic pulse_eret();
        int_eret = 1'b1;
        tick(1);
        int_eret = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_raw = '0; ie = 1'b0; int_ack = 1'b0; int_eret = 1'b0;
        tick(3);
        check("rst_req", int_req, 0);
        check("rst_id",  int_id,  0);
        check("rst_irw", irw,     0);
        rst = 1'b0;
        ie  = 1'b1;
        tick(4);
        check("idle_irw", irw, 0);

        // single request on line 1: pending lands 5 edges after first sample
        irq_raw[1] = 1'b1;
        tick(5);
        check("lat_early_req", int_req, 0);
        tick(1);
        check("single_req", int_req, 1);
        check("single_id",  int_id,  1);
        check("single_irw", irw,     3'b010);
        irq_raw[1] = 1'b0;
        pulse_ack();
        check("single_ack_req", int_req, 0);
        check("single_ack_irw", irw,     3'b010);
        pulse_eret();
        check("single_eret_irw", irw, 0);
        tick(8);
        check("fall_no_req", irw, 0);

        // debounce: 3-cycle glitch rejected, 4-cycle pulse accepted
        press(3'b001, 3);
        tick(10);
        check("glitch_irw", irw,     0);
        check("glitch_req", int_req, 0);
        press(3'b001, 4);
        tick(1);
        check("db_early_irw", irw, 0);
        tick(1);
        check("db_irw", irw,     3'b001);
        check("db_req", int_req, 1);
        check("db_id",  int_id,  0);
        pulse_ack();
        pulse_eret();
        check("db_clear_irw", irw, 0);
        tick(8);

        // nesting
        press(3'b010, 4);
        tick(2);
        pulse_ack();
        check("nest_is1_req", int_req, 0);
        press(3'b101, 4);
        tick(2);
        check("nest_req",  int_req, 1);
        check("nest_id",   int_id,  2);
        check("nest_irw",  irw,     3'b111);
        pulse_ack();
        check("nest_ack2_req", int_req, 0);
        pulse_eret();
        check("nest_eret1_req", int_req, 0);
        check("nest_eret1_irw", irw,     3'b011);
        pulse_eret();
        check("nest_eret2_req", int_req, 1);
        check("nest_eret2_id",  int_id,  0);
        pulse_ack();
        pulse_eret();
        check("nest_done_irw", irw, 0);
        tick(8);

        // masking, ignored ack, ignored eret
        ie = 1'b0;
        press(3'b100, 4);
        tick(2);
        check("mask_req", int_req, 0);
        check("mask_irw", irw,     3'b100);
        pulse_ack();
        check("ack_ignored_irw", irw, 3'b100);
        ie = 1'b1;
        #1;
        check("unmask_req", int_req, 1);
        check("unmask_id",  int_id,  2);
        pulse_eret();
        check("eret_ignored_irw", irw,     3'b100);
        check("eret_ignored_req", int_req, 1);
        pulse_ack();
        pulse_eret();
        check("mask_done_irw", irw, 0);
        tick(8);

        // ack on the same edge as a fresh rise on the same line
        press(3'b010, 4);
        tick(2);
        check("simul_pre_id", int_id, 1);
        tick(8);
        irq_raw[1] = 1'b1;
        tick(5);
        int_ack = 1'b1;
        tick(1);
        int_ack    = 1'b0;
        irq_raw[1] = 1'b0;
        check("simul_irw", irw,     3'b010);
        check("simul_req", int_req, 0);
        pulse_eret();
        check("simul_pend_req", int_req, 1);
        check("simul_pend_id",  int_id,  1);
        pulse_ack();
        pulse_eret();
        check("simul_done_irw", irw, 0);
        tick(8);

        // asynchronous reset mid-run, then a button held across release
        press(3'b011, 4);
        tick(2);
        check("pre_rst_irw", irw, 3'b011);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_req", int_req, 0);
        check("async_rst_irw", irw,     0);
        irq_raw = 3'b100;
        tick(3);
        check("held_rst_irw", irw, 0);
        rst = 1'b0;
        tick(6);
        check("held_req", int_req, 1);
        check("held_id",  int_id,  2);
        pulse_ack();
        tick(10);
        check("held_once_req", int_req, 0);
        check("held_once_irw", irw,     3'b100);
        pulse_eret();
        check("held_done_irw", irw, 0);
        irq_raw = '0;
        tick(2);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
